// File: rtl/rv32_mod_bus_arbiter_if.sv
// Core-side fetch/load-store ports and the shared memory port of the bus arbiter.
// The arbiter takes the slave view; whatever drives requests and models memory takes master.
interface rv32_mod_bus_arbiter_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_ack;
    logic        instr_err;
    logic [31:0] instr_data_o;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_data_i;
    logic        data_ack;
    logic        data_err;
    logic [31:0] data_data_o;

    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_o;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_data_i;

    modport slave (
        input  instr_req, instr_addr,
        output instr_ack, instr_err, instr_data_o,
        input  data_req, data_wr, data_be, data_addr, data_data_i,
        output data_ack, data_err, data_data_o,
        output mem_req, mem_wr, mem_be, mem_addr, mem_data_o,
        input  mem_ack, mem_err, mem_data_i
    );

    modport master (
        output instr_req, instr_addr,
        input  instr_ack, instr_err, instr_data_o,
        output data_req, data_wr, data_be, data_addr, data_data_i,
        input  data_ack, data_err, data_data_o,
        input  mem_req, mem_wr, mem_be, mem_addr, mem_data_o,
        output mem_ack, mem_err, mem_data_i
    );
endinterface

// File: rtl/rv32_mod_bus_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and load/store,
// one transfer at a time, with an optional no-response timeout abort.
module rv32_mod_bus_arbiter #(
    parameter bit          DATA_FIRST = 1'b1,
    parameter bit          FAIR       = 1'b1,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic                    clk,
    input logic                    reset,
    rv32_mod_bus_arbiter_if.slave  bus
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax  = '1;
    localparam logic [CntW-1:0] TmoLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e          state_q, state_d;
    logic            last_data_q, last_data_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;

    logic            pick_data;
    logic            resp;
    logic            tmo_hit;
    logic            xfer_ack;
    logic            xfer_err;
    logic            instr_ack, instr_err, data_ack, data_err;
    logic [31:0]     instr_rdata, data_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_data_q <= 1'b0;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            be_q        <= 4'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    // On a tie, fair mode hands the bus to whichever port did not have it last.
    assign pick_data = bus.data_req &&
                       (!bus.instr_req || (FAIR ? !last_data_q : DATA_FIRST));

    assign resp     = bus.mem_ack | bus.mem_err;
    assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == TmoLast) && !resp;
    assign xfer_err = bus.mem_err | tmo_hit;
    assign xfer_ack = bus.mem_ack & ~bus.mem_err;

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        instr_ack   = 1'b0;
        instr_err   = 1'b0;
        instr_rdata = 32'h0;
        data_ack    = 1'b0;
        data_err    = 1'b0;
        data_rdata  = 32'h0;

        case (state_q)
            StIdle: begin
                if (pick_data) begin
                    state_d     = StBusyD;
                    last_data_d = 1'b1;
                    cnt_d       = '0;
                    wr_d        = bus.data_wr;
                    be_d        = bus.data_be;
                    addr_d      = bus.data_addr;
                    wdata_d     = bus.data_data_i;
                end else if (bus.instr_req) begin
                    state_d     = StBusyI;
                    last_data_d = 1'b0;
                    cnt_d       = '0;
                    wr_d        = 1'b0;
                    be_d        = 4'hF;
                    addr_d      = bus.instr_addr;
                    wdata_d     = 32'h0;
                end
            end
            StBusyI, StBusyD: begin
                if (state_q == StBusyI) begin
                    instr_ack   = xfer_ack;
                    instr_err   = xfer_err;
                    instr_rdata = xfer_ack ? bus.mem_data_i : 32'h0;
                end else begin
                    data_ack    = xfer_ack;
                    data_err    = xfer_err;
                    data_rdata  = xfer_ack ? bus.mem_data_i : 32'h0;
                end
                if (resp || tmo_hit) begin
                    state_d = StIdle;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.mem_req      = (state_q != StIdle);
    assign bus.mem_wr       = wr_q;
    assign bus.mem_be       = be_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_data_o   = wdata_q;
    assign bus.instr_ack    = instr_ack;
    assign bus.instr_err    = instr_err;
    assign bus.instr_data_o = instr_rdata;
    assign bus.data_ack     = data_ack;
    assign bus.data_err     = data_err;
    assign bus.data_data_o  = data_rdata;

endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_rv32_mod_bus_arbiter;

    localparam bit          PFair      = 1'b1;
    localparam bit          PDataFirst = 1'b1;
    localparam int unsigned PTimeout   = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv32_mod_bus_arbiter_if bus ();
    rv32_mod_bus_arbiter_if bf ();

    rv32_mod_bus_arbiter #(
        .DATA_FIRST (PDataFirst),
        .FAIR       (PFair),
        .TIMEOUT    (PTimeout)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rv32_mod_bus_arbiter #(
        .DATA_FIRST (1'b0),
        .FAIR       (1'b0),
        .TIMEOUT    (4)
    ) dut_fix (
        .clk   (clk),
        .reset (reset),
        .bus   (bf)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ireq, dreq, ack, err;
        logic [31:0] rdata;
        logic        e_mreq, e_mwr;
        logic [31:0] e_maddr;
        logic        e_iack, e_ierr, e_dack, e_derr;
        logic [31:0] e_idata, e_ddata;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [137:0] act, input logic [137:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.instr_req = 1'b0; bus.instr_addr = 32'h100;
        bus.data_req = 1'b0; bus.data_wr = 1'b1; bus.data_be = 4'h3;
        bus.data_addr = 32'h2000; bus.data_data_i = 32'hBEEF;
        bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_data_i = 32'h0;
        bf.instr_req = 1'b0; bf.instr_addr = 32'h100;
        bf.data_req = 1'b0; bf.data_wr = 1'b0; bf.data_be = 4'hF;
        bf.data_addr = 32'h2000; bf.data_data_i = 32'h0;
        bf.mem_ack = 1'b0; bf.mem_err = 1'b0; bf.mem_data_i = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        next_cyc();
        next_cyc();
        reset = 1'b0;
    endtask

    function automatic logic [137:0] act_vec();
        return {bus.mem_req, bus.mem_wr, bus.mem_be, bus.mem_addr, bus.mem_data_o,
                bus.instr_ack, bus.instr_err, bus.instr_data_o,
                bus.data_ack, bus.data_err, bus.data_data_o};
    endfunction

    // Reference model state: owner 0 = bus free, 1 = fetch, 2 = load/store
    int          own, cnt, last;
    logic        lat_wr;
    logic [3:0]  lat_be;
    logic [31:0] lat_addr, lat_data;
    logic        ipend, dpend;

    initial begin
        logic [3:0]   e_be;
        logic [31:0]  e_wd;
        logic [137:0] exp_v;

        // ireq dreq ack err rdata | mreq mwr maddr | iack ierr dack derr | idata ddata
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 1'b1, 1'b0, 32'h100,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h100,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 32'h100,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h100,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h77, 1'b1, 1'b1, 32'h2000,
                     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h77};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h2000,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h13, 1'b1, 1'b0, 32'h100,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h100,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h99, 1'b1, 1'b1, 32'h2000,
                     1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h2000,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h2000,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h100,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100,
                     1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h100,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

        do_reset();
        #2;
        chk("reset_state", act_vec(), 138'h0);

        for (int i = 0; i < 15; i++) begin
            bus.instr_req  = vecs[i].ireq;
            bus.data_req   = vecs[i].dreq;
            bus.mem_ack    = vecs[i].ack;
            bus.mem_err    = vecs[i].err;
            bus.mem_data_i = vecs[i].rdata;
            #2;
            e_be = (vecs[i].e_maddr == 32'h0) ? 4'h0 : (vecs[i].e_mwr ? 4'h3 : 4'hF);
            e_wd = (vecs[i].e_maddr == 32'h0) ? 32'h0 : (vecs[i].e_mwr ? 32'hBEEF : 32'h0);
            exp_v = {vecs[i].e_mreq, vecs[i].e_mwr, e_be, vecs[i].e_maddr, e_wd,
                     vecs[i].e_iack, vecs[i].e_ierr, vecs[i].e_idata,
                     vecs[i].e_dack, vecs[i].e_derr, vecs[i].e_ddata};
            chk($sformatf("vec%0d", i), act_vec(), exp_v);
            next_cyc();
        end

        // Memory never answers: error on the 16th busy cycle, then a late ack is ignored
        do_reset();
        bus.data_req = 1'b1;
        #2;
        chk("tmo_idle", {137'h0, bus.mem_req}, 138'h0);
        for (int k = 1; k <= 16; k++) begin
            next_cyc();
            #2;
            chk($sformatf("tmo_busy%0d", k),
                {135'h0, bus.mem_req, bus.data_err, bus.data_ack},
                {135'h0, 1'b1, (k == 16), 1'b0});
        end
        next_cyc();
        bus.data_req = 1'b0;
        bus.mem_ack  = 1'b1;
        #2;
        chk("tmo_late_ack", {134'h0, bus.mem_req, bus.data_ack, bus.data_err, bus.instr_ack},
            138'h0);
        next_cyc();
        bus.mem_ack = 1'b0;

        // Reset during a busy fetch, followed by a stale memory response
        do_reset();
        bus.instr_req = 1'b1;
        next_cyc();
        #2;
        chk("rst_busy", {137'h0, bus.mem_req}, {137'h0, 1'b1});
        next_cyc();
        reset = 1'b1;
        bus.instr_req = 1'b0;
        next_cyc();
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_data_i = 32'h1234;
        #2;
        chk("rst_after", act_vec(), 138'h0);
        next_cyc();
        bus.mem_ack = 1'b0;

        // Fixed priority with instr first: data starves while both are held
        do_reset();
        bf.instr_req = 1'b1;
        bf.data_req  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            next_cyc();
            bf.mem_ack = 1'b1;
            bf.mem_data_i = 32'h500 + t;
            #2;
            chk($sformatf("fix_xfer%0d", t),
                {bf.mem_req, bf.mem_addr, bf.instr_ack, bf.data_ack, bf.data_err,
                 bf.instr_data_o},
                {1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h500 + t});
            next_cyc();
            bf.mem_ack = 1'b0;
        end
        bf.instr_req = 1'b0;
        bf.data_req  = 1'b0;

        // Randomized run against the reference model
        do_reset();
        own = 0; cnt = 0; last = 1;
        lat_wr = 1'b0; lat_be = 4'h0; lat_addr = 32'h0; lat_data = 32'h0;
        ipend = 1'b0; dpend = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            int   r;
            int   win;
            logic tmo, ak, er, ia, ie, da, de;
            if (!ipend && $urandom_range(9) < 4) begin
                ipend = 1'b1;
                bus.instr_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dpend && $urandom_range(9) < 4) begin
                dpend = 1'b1;
                bus.data_wr     = 1'($urandom_range(1));
                bus.data_be     = 4'($urandom_range(15));
                bus.data_addr   = $urandom;
                bus.data_data_i = $urandom;
            end
            bus.instr_req  = ipend;
            bus.data_req   = dpend;
            bus.mem_data_i = $urandom;
            r = int'($urandom_range(99));
            bus.mem_ack = (r < 10) || (r >= 95);
            bus.mem_err = (r >= 92);
            #2;
            tmo = (own != 0) && (PTimeout > 0) && (cnt == int'(PTimeout) - 1) &&
                  !bus.mem_ack && !bus.mem_err;
            ak  = (own != 0) && bus.mem_ack && !bus.mem_err;
            er  = (own != 0) && (bus.mem_err || tmo);
            ia  = (own == 1) && ak;
            ie  = (own == 1) && er;
            da  = (own == 2) && ak;
            de  = (own == 2) && er;
            exp_v = {(own != 0), lat_wr, lat_be, lat_addr, lat_data,
                     ia, ie, (ia ? bus.mem_data_i : 32'h0),
                     da, de, (da ? bus.mem_data_i : 32'h0)};
            chk("random", act_vec(), exp_v);
            if (own != 0) begin
                if (ak || er) begin
                    if (own == 1) ipend = 1'b0;
                    else dpend = 1'b0;
                    own = 0;
                end else begin
                    cnt++;
                end
            end else if (ipend || dpend) begin
                if (ipend && dpend) win = PFair ? 3 - last : (PDataFirst ? 2 : 1);
                else win = ipend ? 1 : 2;
                if (win == 2) begin
                    lat_wr = bus.data_wr; lat_be = bus.data_be;
                    lat_addr = bus.data_addr; lat_data = bus.data_data_i;
                end else begin
                    lat_wr = 1'b0; lat_be = 4'hF;
                    lat_addr = bus.instr_addr; lat_data = 32'h0;
                end
                last = win;
                own  = win;
                cnt  = 0;
            end
            next_cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
